// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, FSM state and address-split types for the instruction cache
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} icache_state_t;
    localparam int ICACHE_IDX_W = 3;
    localparam int ICACHE_BLK_W = 1;
    typedef struct packed {
        logic [29-ICACHE_IDX_W-ICACHE_BLK_W:0] tag;
        logic [ICACHE_IDX_W-1:0]               idx;
        logic [ICACHE_BLK_W-1:0]               blkoff;
        logic [1:0]                            bytoff;
    } icachef_t;
endpackage

// File: rtl/icache_nway_if.sv
// icache_nway_if: datapath-side and memory-side instruction cache interfaces
//   datapath_cache_if: imemREN/imemaddr request, ihit/imemload response
//   caches_if:         iREN/iaddr request, iwait/iload response
interface datapath_cache_if;
    import cpu_types_pkg::*;
    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    modport icache (input imemREN, imemaddr, output ihit, imemload);
    modport dp (output imemREN, imemaddr, input ihit, imemload);
endinterface

interface caches_if;
    import cpu_types_pkg::*;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;
    modport icache (input iwait, iload, output iREN, iaddr);
    modport mem (input iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/icache_way.sv
// icache_way: one way of valid/tag/data frames with a combinational tag-match read port
//   rd_idx/rd_tag/rd_off in -> rd_valid/rd_match/rd_data out
//   wr_en writes wr_data into frame wr_idx word wr_off; fill_done validates the frame with fill_tag
module icache_way
    import cpu_types_pkg::*;
#(
    parameter int NSETS    = 8,
    parameter int BLKWORDS = 2,
    parameter int IDX_W    = 3,
    parameter int BO_W     = 1,
    parameter int TAG_W    = 26
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    input  logic [BO_W-1:0]  rd_off,
    output logic             rd_valid,
    output logic             rd_match,
    output word_t            rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [BO_W-1:0]  wr_off,
    input  word_t            wr_data,
    input  logic             fill_done,
    input  logic [TAG_W-1:0] fill_tag
);
    logic [NSETS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_q [NSETS];
    word_t            data_q [NSETS][BLKWORDS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_match = rd_valid && tag_q[rd_idx] == rd_tag;
    assign rd_data  = data_q[rd_idx][rd_off];

    always_comb begin
        valid_d = valid_q;
        if (fill_done) valid_d[wr_idx] = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // data and tags are only meaningful behind a valid bit, so they skip reset
    always_ff @(posedge CLK) begin
        if (wr_en) data_q[wr_idx][wr_off] <= wr_data;
        if (fill_done) tag_q[wr_idx] <= fill_tag;
    end
endmodule

// File: rtl/icache_nway.sv
// icache_nway: read-only 1/2-way set-associative instruction cache with LRU and block fill FSM
//   CLK, nRST     clock and asynchronous active-low reset
//   dcif (icache) imemREN/imemaddr in, ihit/imemload out (combinational hit)
//   cif  (icache) iwait/iload in, iREN/iaddr out (registered)
//   ICACHE_STATS_EN adds internal saturating hit_count/miss_count counters
module icache_nway
    import cpu_types_pkg::*;
#(
    parameter int NWAYS    = 2,
    parameter int NSETS    = 8,
    parameter int BLKWORDS = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    datapath_cache_if.icache dcif,
    caches_if.icache         cif
);
    localparam int IDX_W   = $clog2(NSETS);
    localparam int BLK_W   = $clog2(BLKWORDS);
    localparam int BO_W    = BLK_W > 0 ? BLK_W : 1;
    localparam int TAG_W   = 30 - IDX_W - BLK_W;
    localparam int IDX_LSB = BLK_W + 2;
    localparam int TAG_LSB = IDX_W + BLK_W + 2;

    icache_state_t    state_q, state_d;
    logic [TAG_W-1:0] tag_q, tag_d, req_tag;
    logic [IDX_W-1:0] idx_q, idx_d, req_idx;
    logic [BO_W-1:0]  k_q, k_d, req_off;
    logic             vic_q, vic_d, iren_q, iren_d;
    word_t            iaddr_q, iaddr_d;
    logic [NSETS-1:0] lru_q, lru_d;
    logic [1:0]       match, valid;
    word_t            rdata [2];
    logic             hit, hit_way, victim, beat, last;

    assign req_tag = dcif.imemaddr[31:TAG_LSB];
    assign req_idx = dcif.imemaddr[TAG_LSB-1:IDX_LSB];
    assign req_off = BO_W'(dcif.imemaddr >> 2) & BO_W'(BLKWORDS - 1);

    // absent second way looks full and never matches, keeping the 2-entry vectors uniform
    for (genvar w = 0; w < 2; w++) begin : g_way
        if (w < NWAYS) begin : g_on
            icache_way #(
                .NSETS(NSETS), .BLKWORDS(BLKWORDS), .IDX_W(IDX_W), .BO_W(BO_W), .TAG_W(TAG_W)
            ) u_way (
                .CLK(CLK), .nRST(nRST),
                .rd_idx(req_idx), .rd_tag(req_tag), .rd_off(req_off),
                .rd_valid(valid[w]), .rd_match(match[w]), .rd_data(rdata[w]),
                .wr_en(beat && vic_q == 1'(w)), .wr_idx(idx_q), .wr_off(k_q), .wr_data(cif.iload),
                .fill_done(beat && last && vic_q == 1'(w)), .fill_tag(tag_q)
            );
        end else begin : g_off
            assign valid[w] = 1'b1;
            assign match[w] = 1'b0;
            assign rdata[w] = '0;
        end
    end

    assign hit     = dcif.imemREN && state_q == IDLE && |match;
    assign hit_way = match[1];
    assign beat    = state_q == FILL && !cif.iwait;
    assign last    = k_q == BO_W'(BLKWORDS - 1);
    assign victim  = NWAYS == 1 ? 1'b0 : !valid[0] ? 1'b0 : !valid[1] ? 1'b1 : lru_q[req_idx];

    assign dcif.ihit     = hit;
    assign dcif.imemload = hit ? rdata[hit_way] : '0;
    assign cif.iREN      = iren_q;
    assign cif.iaddr     = iaddr_q;

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        k_d     = k_q;
        vic_d   = vic_q;
        lru_d   = lru_q;
        if (state_q == IDLE && dcif.imemREN && !hit) begin
            state_d = FILL;
            tag_d   = req_tag;
            idx_d   = req_idx;
            k_d     = '0;
            vic_d   = victim;
        end
        if (hit) lru_d[req_idx] = ~hit_way;
        if (beat) begin
            k_d = last ? '0 : k_q + 1'b1;
            if (last) begin
                state_d       = IDLE;
                lru_d[idx_q]  = ~vic_q;
            end
        end
        if (NWAYS == 1) lru_d = '0;
        // the memory request is registered from next-state so it lines up with the FILL cycles
        iren_d  = state_d == FILL;
        iaddr_d = iren_d ? (32'(tag_d) << TAG_LSB) | (32'(idx_d) << IDX_LSB) | (32'(k_d) << 2) : '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            tag_q   <= '0;
            idx_q   <= '0;
            k_q     <= '0;
            vic_q   <= 1'b0;
            lru_q   <= '0;
            iren_q  <= 1'b0;
            iaddr_q <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            vic_q   <= vic_d;
            lru_q   <= lru_d;
            iren_q  <= iren_d;
            iaddr_q <= iaddr_d;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit && ~&hit_count_q ? hit_count_q + 32'd1 : hit_count_q;
        miss_count_d = state_q == IDLE && state_d == FILL && ~&miss_count_q ? miss_count_q + 32'd1 : miss_count_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end
`else
`endif
endmodule

// File: tb/tb_icache_nway.sv
// tb_icache_nway: checks a 2-way and a direct-mapped icache against a recency-list cache model
module tb_icache_nway;
    import cpu_types_pkg::*;

    logic             CLK, nRST;
    logic [1:0]       ren, ihit, iren_o, iwait;
    logic [1:0][31:0] addr, load, iaddr_o;
    int               wait_w;
    int               errors, checks;

    logic [31:0] rec [2][8][$];
    logic [1:0]  busy;
    logic [31:0] fblk [2];
    int          fk [2];
    logic        e_hit, e_ren;
    logic [31:0] e_load, e_addr, blk;
    int          pos, lat, n;
    logic [31:0] d;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC0DE0000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        datapath_cache_if dcif ();
        caches_if         cif ();
        int               wcnt;
        icache_nway #(.NWAYS(2 - g), .NSETS(8), .BLKWORDS(2)) dut (
            .CLK(CLK), .nRST(nRST), .dcif(dcif), .cif(cif)
        );
        assign dcif.imemREN  = ren[g];
        assign dcif.imemaddr = addr[g];
        assign ihit[g]       = dcif.ihit;
        assign load[g]       = dcif.imemload;
        assign iren_o[g]     = cif.iREN;
        assign iaddr_o[g]    = cif.iaddr;
        assign iwait[g]      = cif.iREN && (wcnt < wait_w);
        assign cif.iwait     = iwait[g];
        assign cif.iload     = cif.iREN ? mem(cif.iaddr) : '0;
        always @(posedge CLK or negedge nRST) begin
            if (!nRST) wcnt <= 0;
            else if (!cif.iREN || !iwait[g]) wcnt <= 0;
            else wcnt <= wcnt + 1;
        end
    end

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, g, act, exp, $time);
        end
    endtask

    task automatic touch(input int g, input logic [31:0] b);
        int s = int'(b % 8);
        for (int i = rec[g][s].size() - 1; i >= 0; i--)
            if (rec[g][s][i] == b) rec[g][s].delete(i);
        rec[g][s].push_front(b);
        if (rec[g][s].size() > 2 - g) void'(rec[g][s].pop_back());
    endtask

    // model: per set a most-recent-first list of block numbers, capacity = ways
    initial begin
        busy = '0;
        forever begin
            @(negedge CLK);
            for (int g = 0; g < 2; g++) begin
                e_hit = 1'b0; e_load = '0; e_ren = 1'b0; e_addr = '0;
                if (!nRST) begin
                    busy[g] = 1'b0;
                    for (int s = 0; s < 8; s++) rec[g][s].delete();
                end else if (busy[g]) begin
                    e_ren  = 1'b1;
                    e_addr = (fblk[g] << 3) + 32'(fk[g] * 4);
                    if (!iwait[g]) begin
                        fk[g]++;
                        if (fk[g] == 2) begin
                            busy[g] = 1'b0;
                            touch(g, fblk[g]);
                        end
                    end
                end else if (ren[g]) begin
                    blk = addr[g] >> 3;
                    pos = -1;
                    for (int i = 0; i < rec[g][int'(blk % 8)].size(); i++)
                        if (rec[g][int'(blk % 8)][i] == blk) pos = i;
                    if (pos >= 0) begin
                        e_hit  = 1'b1;
                        e_load = mem(addr[g]);
                        touch(g, blk);
                    end else begin
                        busy[g] = 1'b1;
                        fblk[g] = blk;
                        fk[g]   = 0;
                    end
                end
                chk("ihit", g, 32'(ihit[g]), 32'(e_hit));
                chk("imemload", g, load[g], e_load);
                chk("iREN", g, 32'(iren_o[g]), 32'(e_ren));
                chk("iaddr", g, iaddr_o[g], e_addr);
            end
        end
    end

    task automatic req(input int g, input logic [31:0] a, output int l, output logic [31:0] dout);
        @(posedge CLK); #1;
        ren[g]  = 1'b1;
        addr[g] = a;
        l = 0;
        @(negedge CLK);
        while (!ihit[g] && l < 40) begin
            @(negedge CLK);
            l++;
        end
        dout = load[g];
        @(posedge CLK); #1;
        ren[g] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        errors = 0; checks = 0;
        nRST = 1'b0; ren = '0; addr = '0; wait_w = 2;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ihit", 0, 32'(ihit[0]), 32'd0);
        chk("rst_iren", 0, 32'(iren_o[0]), 32'd0);
        chk("rst_iaddr", 0, iaddr_o[0], 32'd0);
        @(posedge CLK); #1 nRST = 1'b1;

        @(posedge CLK); #1;
        ren[0] = 1'b1; addr[0] = 32'h40;
        @(negedge CLK);
        chk("cold_c0_ihit", 0, 32'(ihit[0]), 32'd0);
        @(negedge CLK);
        chk("cold_c1_iren", 0, 32'(iren_o[0]), 32'd1);
        chk("cold_c1_iaddr", 0, iaddr_o[0], 32'h40);
        repeat (3) @(negedge CLK);
        chk("cold_c4_iaddr", 0, iaddr_o[0], 32'h44);
        repeat (3) @(negedge CLK);
        chk("cold_c7_ihit", 0, 32'(ihit[0]), 32'd1);
        chk("cold_c7_data", 0, load[0], 32'hC0DE0040);
        chk("cold_c7_iren", 0, 32'(iren_o[0]), 32'd0);
        @(posedge CLK); #1 ren[0] = 1'b0;

        req(0, 32'h44, lat, d);
        chk("spatial_lat", 0, 32'(lat), 32'd0);
        chk("spatial_data", 0, d, 32'hC0DE0044);

        wait_w = 1;
        req(0, 32'h140, lat, d);
        chk("conf_fill140", 0, 32'(lat), 32'd5);
        req(0, 32'h40, lat, d);
        chk("conf_hit040", 0, 32'(lat), 32'd0);
        req(0, 32'h240, lat, d);
        chk("conf_fill240", 0, 32'(lat), 32'd5);
        chk("conf_data240", 0, d, 32'hC0DE0240);
        req(0, 32'h44, lat, d);
        chk("conf_hit044", 0, 32'(lat), 32'd0);
        req(0, 32'h140, lat, d);
        chk("conf_evict140", 0, 32'(lat), 32'd5);

        wait_w = 0;
        req(1, 32'h40, lat, d);
        chk("dm_fill040", 1, 32'(lat), 32'd3);
        req(1, 32'h140, lat, d);
        chk("dm_fill140", 1, 32'(lat), 32'd3);
        req(1, 32'h40, lat, d);
        chk("dm_remiss040", 1, 32'(lat), 32'd3);
        req(1, 32'h44, lat, d);
        chk("dm_hit044", 1, 32'(lat), 32'd0);

        wait_w = 1;
        @(posedge CLK); #1;
        ren[0] = 1'b1; addr[0] = 32'h1008;
        n = 0;
        @(negedge CLK);
        while (iaddr_o[0] !== 32'h100C && n < 20) begin @(negedge CLK); n++; end
        chk("abort_word1_cycle", 0, 32'(n), 32'd3);
        @(posedge CLK); #1;
        ren[0] = 1'b0; addr[0] = 32'h2000;
        n = 0;
        @(negedge CLK);
        while (iren_o[0] && n < 20) begin @(negedge CLK); n++; end
        chk("abort_iren_tail", 0, 32'(n), 32'd1);
        req(0, 32'h1008, lat, d);
        chk("abort_valid_lat", 0, 32'(lat), 32'd0);
        chk("abort_valid_data", 0, d, 32'hC0DE1008);

        wait_w = 2;
        @(posedge CLK); #1;
        ren[0] = 1'b1; addr[0] = 32'h10;
        n = 0;
        @(negedge CLK);
        while (iaddr_o[0] !== 32'h14 && n < 20) begin @(negedge CLK); n++; end
        chk("rstfill_word1", 0, iaddr_o[0], 32'h14);
        @(posedge CLK); #1;
        nRST = 1'b0; ren[0] = 1'b0;
        @(negedge CLK);
        chk("rstfill_iren", 0, 32'(iren_o[0]), 32'd0);
        chk("rstfill_iaddr", 0, iaddr_o[0], 32'd0);
        @(posedge CLK); #1 nRST = 1'b1;
        req(0, 32'h10, lat, d);
        chk("rstfill_refill", 0, 32'(lat), 32'd7);
        chk("rstfill_data", 0, d, 32'hC0DE0010);
        req(0, 32'h40, lat, d);
        chk("rst_cleared040", 0, 32'(lat), 32'd7);

        repeat (2) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_nway.md
ICACHE_NWAY -- requirements
Module: icache_nway

Interface
- REQ-001 The parameter NWAYS SHALL be declared as: NWAYS, 2, associativity; legal values 1 or 2.
- REQ-002 The parameter NSETS SHALL be declared as: NSETS, 8, sets per way; power of two, 2..64.
- REQ-003 The parameter BLKWORDS SHALL be declared as: BLKWORDS, 2, 32-bit words per block; power of two, 1..4.
- REQ-004 The port CLK SHALL be declared as: CLK, input, 1, single clock; all state updates on rising edge.
- REQ-005 The port nRST SHALL be declared as: nRST, input, 1, asynchronous active-low reset.
- REQ-006 The port dcif SHALL be declared as: dcif, modport datapath_cache_if.icache, -, imemREN/imemaddr in; ihit/imemload out.
- REQ-007 The port cif SHALL be declared as: cif, modport caches_if.icache, -, iload/iwait in; iREN/iaddr out.

Function
- REQ-008 The address split SHALL be imemaddr = {tag, idx[log2 NSETS], blkoff[log2 BLKWORDS], bytoff[2]}, with tag taking the remaining bits.
- REQ-009 Each way/set frame SHALL hold the following fields: valid, tag, and BLKWORDS data words.
- REQ-010 Each set SHALL hold one LRU bit when NWAYS=2; the bit names the least-recently-used way.
- REQ-011 A hit SHALL be imemREN=1, state IDLE, and a valid frame in set idx whose tag matches.
- REQ-012 A hit SHALL be combinational: ihit=1 and imemload=data[hit way][blkoff] in the same cycle, with zero wait.
- REQ-013 ihit SHALL be 0 whenever imemREN=0, on a miss, and in any state other than IDLE.
- REQ-014 When ihit=0, imemload SHALL be 0.
- REQ-015 The FSM SHALL have the states IDLE and FILL, encoded in 1 bit.
- REQ-016 IDLE->FILL SHALL occur on imemREN=1 with no hit.
- REQ-017 On IDLE->FILL, the block SHALL latch the miss tag and idx, clear the word counter k to 0, and select the victim.
- REQ-018 Victim selection SHALL choose the lowest-numbered invalid way in the set; if both ways are valid, it SHALL choose the LRU way; with NWAYS=1 it SHALL choose way 0.
- REQ-019 In FILL, the block SHALL drive iREN=1 and iaddr={latched tag, latched idx, k, 2'b00}.
- REQ-020 In FILL, each cycle with iwait=0 SHALL write iload into victim data[k] and increment k.
- REQ-021 In FILL, a cycle with iwait=1 SHALL hold k and iaddr unchanged.
- REQ-022 The cycle in FILL with iwait=0 and k=BLKWORDS-1 SHALL set the victim's valid and tag, update LRU, and transition to IDLE.
- REQ-023 The hit SHALL be reported in the IDLE cycle after that FILL exit.
- REQ-024 The latency for a miss with a memory wait of W cycles per word SHALL be BLKWORDS*(W+1)+1 cycles from request to ihit.
- REQ-025 In IDLE, iREN SHALL be 0 and iaddr SHALL be 0.
- REQ-026 On a hit to way w, the LRU bit SHALL be set to ~w; on a fill into way v, the LRU bit SHALL be set to ~v.
- REQ-027 A fill SHALL always run to completion, even if imemREN drops or imemaddr changes mid-fill; a partial block SHALL never become valid.
- REQ-028 After a fill completes, a request to a different address SHALL be evaluated fresh in IDLE.
- REQ-029 The block SHALL contain no write path; instruction memory is read-only.

Reset
- REQ-030 While nRST=0, the block SHALL clear all valid bits, LRU bits, and the counter k to 0, and set the state to IDLE.
- REQ-031 While nRST=0, ihit, imemload, iREN, and iaddr SHALL be 0.
- REQ-032 A reset asserted mid-FILL SHALL abandon the fill with no frame left valid; data arrays need not be cleared.

Configuration
- REQ-033 The feature SHALL be controlled by the macro ICACHE_STATS_EN.
- REQ-034 When ICACHE_STATS_EN is defined, the block SHALL contain internal 32-bit counters hit_count (incremented per ihit cycle) and miss_count (incremented per IDLE->FILL); both SHALL saturate at 32'hFFFFFFFF and reset to 0.
- REQ-035 When ICACHE_STATS_EN is undefined, the counters SHALL be absent, and port and functional behaviour SHALL be identical.

Structure
- REQ-036 A parametrised address-split typedef and the FSM state enum SHALL be placed in cpu_types_pkg, and word_t SHALL come from it.
- REQ-037 One sub-module, icache_way (a single way's tag/valid/data array with match output), SHALL be instantiated NWAYS times; LRU and the FSM SHALL stay in the top level.

Verification
- REQ-038 Verification SHALL cover a cold miss: after reset, read 0x00000040 with iwait=1 for 2 cycles per word and BLKWORDS=2 -> iaddr 0x40 then 0x44, and ihit on cycle 7 with data from 0x40.
- REQ-039 Verification SHALL cover spatial hit: after the cold-miss fill, read 0x00000044 -> ihit in the same cycle with no iREN.
- REQ-040 Verification SHALL cover conflict with 2 ways and NSETS=8: fill 0x040, fill 0x140 (same idx), then read 0x040 -> hit, then fill 0x240 -> way holding 0x140 evicted, and 0x040 still hits.
- REQ-041 Verification SHALL cover direct-mapped mode (NWAYS=1): fill 0x040, then 0x140 -> re-read of 0x040 misses.
- REQ-042 Verification SHALL cover abort robustness: drop imemREN after word 0 of a fill -> FILL completes, iREN stays 1 until the last word, and the block is valid afterwards.
- REQ-043 Verification SHALL cover reset mid-FILL: then read the same address -> miss, with a full refill starting at k=0.
